// File: rtl/pll_lock_detect.sv
// PLL lock detector: counts synchronized ref/fb rising edges over fixed clk_out windows
// and declares lock after LOCK_CNT consecutive matching windows. Full-scan capable.
module pll_lock_detect #(
    parameter int unsigned WIN_LOG2 = 6,
    parameter int unsigned TOL      = 1,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic clk_out,
    input  logic rst_n,
    input  logic clk_ref,
    input  logic clk_fb,
    input  logic scan_en,
    input  logic scan_in,
    output logic locked,
    output logic fb_slow,
    output logic fb_fast,
    output logic scan_out
);

    localparam int unsigned W     = WIN_LOG2;
    localparam int unsigned GCW   = 4;
    localparam int unsigned CHAIN = 6 + 3 * W + GCW + 2 + 3;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_e;

    // Synchronizer vectors: bit0 = s1, bit1 = s2, bit2 = s3
    logic [2:0]     ref_sync_q, ref_sync_d;
    logic [2:0]     fb_sync_q, fb_sync_d;
    logic [W-1:0]   win_cnt_q, win_cnt_d;
    logic [W-1:0]   ref_edges_q, ref_edges_d;
    logic [W-1:0]   fb_edges_q, fb_edges_d;
    logic [GCW-1:0] good_cnt_q, good_cnt_d;
    state_e         state_q, state_d;
    logic           fb_slow_q, fb_slow_d;
    logic           fb_fast_q, fb_fast_d;
    logic           locked_q, locked_d;

    logic           ref_pulse, fb_pulse, win_end, good;
    logic [W-1:0]   ref_eval, fb_eval;
    int unsigned    rv, fv, diff;
    logic [CHAIN-1:0] chain_nxt;
    logic [1:0]     scan_state;

    assign ref_pulse = ref_sync_q[1] & ~ref_sync_q[2];
    assign fb_pulse  = fb_sync_q[1] & ~fb_sync_q[2];
    assign win_end   = &win_cnt_q;

    // Saturating count including this cycle's pulse; also the value evaluated at window end
    assign ref_eval = (&ref_edges_q) ? ref_edges_q : ref_edges_q + {{(W-1){1'b0}}, ref_pulse};
    assign fb_eval  = (&fb_edges_q)  ? fb_edges_q  : fb_edges_q  + {{(W-1){1'b0}}, fb_pulse};

    assign rv   = 32'(ref_eval);
    assign fv   = 32'(fb_eval);
    assign diff = (rv >= fv) ? (rv - fv) : (fv - rv);
    assign good = (rv != 0) && (fv != 0) && (diff <= TOL);

    // Next chain contents: every flop takes its predecessor, locked_q is the tail
    assign chain_nxt = {fb_fast_q, fb_slow_q, state_q, good_cnt_q, fb_edges_q,
                        ref_edges_q, win_cnt_q, fb_sync_q, ref_sync_q, scan_in};

    always_comb begin
        ref_sync_d  = ref_sync_q;
        fb_sync_d   = fb_sync_q;
        win_cnt_d   = win_cnt_q;
        ref_edges_d = ref_edges_q;
        fb_edges_d  = fb_edges_q;
        good_cnt_d  = good_cnt_q;
        state_d     = state_q;
        fb_slow_d   = fb_slow_q;
        fb_fast_d   = fb_fast_q;
        locked_d    = locked_q;
        scan_state  = 2'd0;

        if (scan_en) begin
            {locked_d, fb_fast_d, fb_slow_d, scan_state, good_cnt_d, fb_edges_d,
             ref_edges_d, win_cnt_d, fb_sync_d, ref_sync_d} = chain_nxt;
            state_d = state_e'(scan_state);
        end else begin
            ref_sync_d  = {ref_sync_q[1:0], clk_ref};
            fb_sync_d   = {fb_sync_q[1:0], clk_fb};
            win_cnt_d   = win_cnt_q + 1'b1;
            ref_edges_d = ref_eval;
            fb_edges_d  = fb_eval;

            if (win_end) begin
                ref_edges_d = '0;
                fb_edges_d  = '0;
                fb_slow_d   = rv > fv + TOL;
                fb_fast_d   = fv > rv + TOL;
            end

            case (state_q)
                UNLOCKED: begin
                    if (win_end && good) begin
                        good_cnt_d = GCW'(1);
                        state_d    = (LOCK_CNT <= 1) ? LOCKED : ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (win_end) begin
                        if (good) begin
                            good_cnt_d = good_cnt_q + 1'b1;
                            if (32'(good_cnt_q) + 32'd1 >= LOCK_CNT) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            good_cnt_d = '0;
                            state_d    = UNLOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (win_end && !good) begin
                        good_cnt_d = '0;
                        state_d    = UNLOCKED;
                    end
                end
                default: begin
                    good_cnt_d = '0;
                    state_d    = UNLOCKED;
                end
            endcase

            locked_d = (state_d == LOCKED);
        end
    end

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            ref_sync_q  <= '0;
            fb_sync_q   <= '0;
            win_cnt_q   <= '0;
            ref_edges_q <= '0;
            fb_edges_q  <= '0;
            good_cnt_q  <= '0;
            state_q     <= UNLOCKED;
            fb_slow_q   <= 1'b0;
            fb_fast_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            ref_sync_q  <= ref_sync_d;
            fb_sync_q   <= fb_sync_d;
            win_cnt_q   <= win_cnt_d;
            ref_edges_q <= ref_edges_d;
            fb_edges_q  <= fb_edges_d;
            good_cnt_q  <= good_cnt_d;
            state_q     <= state_d;
            fb_slow_q   <= fb_slow_d;
            fb_fast_q   <= fb_fast_d;
            locked_q    <= locked_d;
        end
    end

    assign locked   = locked_q;
    assign fb_slow  = fb_slow_q;
    assign fb_fast  = fb_fast_q;
    assign scan_out = locked_q;

endmodule
